// File: rtl/handshake_responder_fifo.sv
// -----------------------------------------------------------------------------
// handshake_responder_fifo
//
// Responder end of the req/ack pull handshake between dataflow operators.
// Upstream logic pushes words into an internal circular buffer. A downstream
// requester holds req high and receives one word per single-cycle ack pulse.
// dout is registered and valid in the same cycle as ack.
//
// Ports:
//   clk       rising-edge clock for all logic
//   rst       synchronous, active-high reset
//   wr_en     push strobe from upstream
//   wr_data   word to push
//   full      buffer holds depth entries
//   empty     buffer holds no entries
//   level     number of stored entries, 0..depth
//   overflow  sticky flag, set by a push attempted while full
//   req       level request from the downstream requester
//   ack       one-cycle pulse, dout valid in the same cycle
//   dout      registered word delivered with ack, held between acks
//   count     number of acks issued since reset, wraps modulo 2^32
// -----------------------------------------------------------------------------
module handshake_responder_fifo #(
   parameter int data_width = 32,
   parameter int depth      = 16,
   parameter int addr_width = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [data_width-1:0] wr_data,
   output logic                  full,
   output logic                  empty,
   output logic [addr_width:0]   level,
   output logic                  overflow,
   input  logic                  req,
   output logic                  ack,
   output logic [data_width-1:0] dout,
   output logic [31:0]           count
);

   // Storage and pointers. Pointers carry one extra MSB so that full and
   // empty can be told apart when the low address bits coincide.
   logic [data_width-1:0] mem [depth];
   logic [addr_width:0]   wr_ptr;
   logic [addr_width:0]   rd_ptr;

   logic push;
   logic push_blocked;
   logic pop;

   // Status flags come purely from the registered pointers, so they never
   // depend combinationally on wr_en or req.
   assign full  = (wr_ptr[addr_width] != rd_ptr[addr_width]) &&
                  (wr_ptr[addr_width-1:0] == rd_ptr[addr_width-1:0]);
   assign empty = (wr_ptr == rd_ptr);
   assign level = wr_ptr - rd_ptr;

   // A push is accepted only against the pre-edge full flag, so a push that
   // coincides with a pop on a full buffer is still dropped.
   assign push         = wr_en & ~full;
   assign push_blocked = wr_en & full;

   // The ~ack term stops a second pop on the edge where the requester has
   // not yet had the chance to drop req after seeing the previous ack.
   assign pop = req & ~ack & ~empty;

   // Buffer write port. Kept separate from the reset logic so the array can
   // map onto plain memory; a word written at edge E becomes visible to the
   // read side only from edge E+1 through the pointer compare.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         mem[wr_ptr[addr_width-1:0]] <= wr_data;
      end
   end

   // Write pointer advances on every accepted push and wraps naturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
      end else if (push) begin
         wr_ptr <= wr_ptr + (addr_width+1)'(1);
      end
   end

   // Overflow is sticky: once a word has been dropped the parent must reset
   // to clear the indication.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow <= 1'b0;
      end else if (push_blocked) begin
         overflow <= 1'b1;
      end
   end

   // Read side of the handshake. ack is a pure one-cycle pulse; dout is only
   // loaded on a pop and otherwise keeps the last delivered word.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         ack    <= 1'b0;
         dout   <= '0;
         count  <= '0;
      end else begin
         ack <= pop;
         if (pop) begin
            dout   <= mem[rd_ptr[addr_width-1:0]];
            rd_ptr <= rd_ptr + (addr_width+1)'(1);
            count  <= count + 32'd1;
         end
      end
   end

endmodule

// File: doc/handshake_responder_fifo.md
Name: handshake_responder_fifo

Overview:
- Responder end of the req/ack pull handshake used between dataflow operators, for designs that take data from a synthesizable push source instead of the bench producer.
- Upstream logic pushes words into an internal FIFO; a downstream requester (an "in" async_operator) raises req and receives one word per one-cycle ack pulse.
- Sits at the arf input boundary, driving the din_req/din_ack/din triple.

Parameters:
- data_width, 32, width of data words.
- depth, 16, FIFO entries; must be a power of 2, at least 2.
- addr_width, 4, log2(depth); the parent supplies it consistent with depth.

Ports:
- clk  input  1  clock, all logic on the rising edge.
- rst  input  1  synchronous reset, active-high.
- wr_en  input  1  push strobe from upstream.
- wr_data  input  data_width  word to push.
- full  output  1  FIFO holds depth entries.
- empty  output  1  FIFO holds 0 entries.
- level  output  addr_width+1  current number of entries, 0..depth.
- overflow  output  1  sticky; set when wr_en is asserted while full.
- req  input  1  level request from the downstream requester.
- ack  output  1  one-cycle pulse; dout is valid in the same cycle.
- dout  output  data_width  registered word delivered with ack.
- count  output  32  number of acks issued since reset; wraps modulo 2^32.

Behaviour:
- Reset: ack=0, dout=0, count=0, overflow=0, level=0, empty=1, full=0. Read and write pointers return to 0. Any pending req is ignored during reset, and an ack in progress is cancelled.
- Storage: a circular buffer of depth entries with pointers addr_width+1 bits wide.
  - full when the pointers' MSBs differ and the low bits are equal.
  - empty when the pointers are equal.
  - Pointers wrap naturally.
- Push:
  - On an edge with wr_en=1 and full=0, wr_data is written at the write pointer and the pointer increments.
  - wr_en=1 with full=1: the word is dropped, the pointers are unchanged, and overflow is set to 1 until reset.
  - full is evaluated from the pre-edge state, so a push while full is dropped even if a pop happens on the same edge.
- Pop / handshake:
  - On an edge where req=1, ack=0 and empty=0: ack<=1, dout<=the entry at the read pointer, the read pointer increments, and count increments.
  - On every other edge ack<=0, so ack is never high for two consecutive cycles.
  - The requester clears req one edge after seeing ack. The ack=0 guard prevents a second pop on that edge.
  - dout holds its last value when ack=0.
- Latency:
  - A word pushed at edge E is eligible for pop at edge E+1 at the earliest, so ack is visible after E+1. There is no bypass from wr_data to dout.
  - With req held continuously high and data available, acks occur every second cycle (maximum rate 1 word / 2 clocks).
- Simultaneous push and pop on one edge (not full, not empty): both happen and level is unchanged.
- Empty with req=1: no ack; req stays pending until a word arrives, then ack fires on the edge after the push.
- req dropping without an ack: no state change.
- Ordering: strictly FIFO. Data is never reordered, duplicated, or lost except via overflow.
- level, full, empty are registered or derived from registered pointers only. They have no combinational path from wr_en or req.

Test Plan:
- Reset then idle, req=0, 10 cycles: ack never 1, dout=0, count=0, empty=1, level=0.
- Push 5,6,7 on consecutive edges with req held 1: acks with dout=5,6,7 in order, no two adjacent ack cycles, count=3, ending empty=1.
- Push 16 words 0..15 with req=0: full=1, level=16. Push 99: overflow=1 and 99 is never delivered. Then raise req: 0..15 are delivered, then no further ack.
- req=1 with FIFO empty for 8 cycles, then push 42 at edge E: ack=1 and dout=42 exactly after edge E+1.
- Steady state, push every cycle while req toggles per the requester protocol: level stays bounded, delivered sequence equals pushed sequence, count equals number of ack pulses.
- Assert rst for one cycle mid-stream with level=4: afterwards ack=0, level=0, count=0, overflow=0. Next push 1 is the next word delivered.
